// File: rtl/fft_store_pkg.sv
// fft_store_pkg
//   Shared types and helpers for the FFT sample store.
//   - store_fsm     : LOAD -> START -> CALC -> DONE buffer ownership states
//   - bitrev()      : bit-reversed address over log2n bits
//   - floor_log2()  : index of the highest set bit of N
//   - n_invalid()   : N is outside 2..2**MAX_LOG2N or not a power of two
package fft_store_pkg;

  localparam int         STORE_ADDR_W = 12;
  localparam int         STORE_DATA_W = 32;
  localparam logic [3:0] MAX_LOG2N    = 4'd11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_CALC  = 2'd2,
    ST_DONE  = 2'd3
  } store_fsm;

  // Reverse all STORE_ADDR_W bits, then shift the unused low-order positions
  // back out, which leaves the reversal of the low log2n bits only.
  function automatic logic [STORE_ADDR_W-1:0] bitrev(
    input logic [STORE_ADDR_W-1:0] addr,
    input logic [3:0]              log2n
  );
    logic [STORE_ADDR_W-1:0] rev;
    logic [3:0]              sh;
    for (int i = 0; i < STORE_ADDR_W; i++) begin
      rev[i] = addr[STORE_ADDR_W-1-i];
    end
    sh = 4'(STORE_ADDR_W) - log2n;
    return rev >> sh;
  endfunction

  // N = 0 yields 0; callers flag that case through n_invalid().
  function automatic logic [3:0] floor_log2(input logic [STORE_ADDR_W-1:0] n);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < STORE_ADDR_W; i++) begin
      if (n[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic n_invalid(input logic [STORE_ADDR_W-1:0] n);
    logic not_pow2;
    not_pow2 = ((n & (n - STORE_ADDR_W'(1))) != STORE_ADDR_W'(0));
    return (n < STORE_ADDR_W'(2)) || not_pow2 || (floor_log2(n) > MAX_LOG2N);
  endfunction

endpackage

// File: rtl/fft_store_mem.sv
// fft_store_mem
//   Single-clock sample RAM.
//   Ports:
//     i_clk, i_rst        clock; synchronous active-high reset (read register only)
//     i_we/i_waddr/i_wdata one synchronous write port (muxed by the owner FSM)
//     i_re/i_raddr/o_rdata registered read port for the FFT core; holds when !i_re
//     i_baddr/o_bdata     asynchronous read port for the bridge
//   A same-cycle write and registered read of one address returns the old word.
module fft_store_mem
  import fft_store_pkg::*;
#(
  parameter int ADDR_WIDTH = STORE_ADDR_W,
  parameter int DATA_WIDTH = STORE_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic [ADDR_WIDTH-1:0] i_baddr,
  output logic [DATA_WIDTH-1:0] o_bdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array: written, never cleared.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end else begin
      mem_r[i_waddr] <= mem_r[i_waddr];
    end
  end

  // Core read register: samples the array before this cycle's write lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (i_re) begin
      rdata_r <= mem_r[i_raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign o_rdata = rdata_r;
  assign o_bdata = mem_r[i_baddr];

endmodule

// File: rtl/fft_sample_store.sv
// fft_sample_store
//   Sample memory between the AXI bridge and the FFT core.
//   LOAD : bridge writes {sample,16'h0} at bit-reversed index
//   START: one-cycle o_START, then the core owns memory in CALC
//   DONE : bridge reads results in natural order, zero latency on o_DATA
//   Ports:
//     i_clk, i_rst                     clock, synchronous active-high reset
//     i_SAMPLE, i_SAMPLE_INDEX         bridge sample / index
//     i_WRITE, i_READ, i_DATA_LOADED   bridge strobes
//     i_SAMPLES_NUMBER                 N (power of two)
//     o_DATA, o_CALC_END               bridge result path
//     o_START, o_LOG2N                 core handshake / transform size
//     i_CORE_ADDR/WE/WDATA, o_CORE_RDATA, i_CORE_DONE  core memory port
//     o_ERR                            sticky protocol error
module fft_sample_store
  import fft_store_pkg::*;
#(
  parameter int ADDR_WIDTH = STORE_ADDR_W,
  parameter int DATA_WIDTH = STORE_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_SAMPLE,
  input  logic [ADDR_WIDTH-1:0] i_SAMPLE_INDEX,
  input  logic                  i_WRITE,
  input  logic                  i_READ,
  input  logic                  i_DATA_LOADED,
  input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_CALC_END,
  output logic                  o_START,
  output logic [3:0]            o_LOG2N,
  input  logic [ADDR_WIDTH-1:0] i_CORE_ADDR,
  input  logic                  i_CORE_WE,
  input  logic [DATA_WIDTH-1:0] i_CORE_WDATA,
  output logic [DATA_WIDTH-1:0] o_CORE_RDATA,
  input  logic                  i_CORE_DONE,
  output logic                  o_ERR
);

  store_fsm              state_r, state_s;
  logic [ADDR_WIDTH-1:0] n_r, n_cur_s, last_idx_s;
  logic [3:0]            log2n_r, log2n_cur_s;
  logic                  n_bad_s, idx_oob_s, err_set_s;
  logic                  start_r, calc_end_r, err_r;
  logic                  mem_we_s, core_re_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s, bdata_s;

  // Size in effect: live input while loading, frozen copy afterwards.
  always_comb begin
    n_cur_s     = n_r;
    log2n_cur_s = log2n_r;
    if (state_r == ST_LOAD) begin
      n_cur_s     = i_SAMPLES_NUMBER;
      log2n_cur_s = floor_log2(i_SAMPLES_NUMBER);
    end else begin
      n_cur_s     = n_r;
      log2n_cur_s = log2n_r;
    end
  end

  assign n_bad_s    = n_invalid(n_cur_s);
  assign idx_oob_s  = (i_SAMPLE_INDEX >= n_cur_s);
  assign last_idx_s = n_cur_s - ADDR_WIDTH'(1);

  // Next-state logic for buffer ownership.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD:  if (i_DATA_LOADED) state_s = ST_START; else state_s = ST_LOAD;
      ST_START: state_s = ST_CALC;
      ST_CALC:  if (i_CORE_DONE) state_s = ST_DONE; else state_s = ST_CALC;
      ST_DONE:  if (i_READ && (i_SAMPLE_INDEX == last_idx_s)) state_s = ST_LOAD;
                else state_s = ST_DONE;
      default:  state_s = ST_LOAD;
    endcase
  end

  // Protocol error detection; a core-done outside CALC is deliberately benign.
  always_comb begin
    err_set_s = 1'b0;
    case (state_r)
      ST_LOAD:  err_set_s = (i_WRITE && (n_bad_s || idx_oob_s)) ||
                            (i_DATA_LOADED && n_bad_s) || i_READ;
      ST_DONE:  err_set_s = i_WRITE;
      default:  err_set_s = i_WRITE || i_READ;
    endcase
  end

  // Write-port mux: bridge owns it in LOAD, core in CALC. Writes with a bad N
  // are dropped as well, so a misconfigured load cannot scribble memory.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {ADDR_WIDTH{1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    if (i_rst) begin
      mem_we_s = 1'b0;
    end else if ((state_r == ST_LOAD) && i_WRITE && !n_bad_s && !idx_oob_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = bitrev(i_SAMPLE_INDEX, log2n_cur_s);
      mem_wdata_s = {i_SAMPLE, 16'h0000};
    end else if ((state_r == ST_CALC) && i_CORE_WE) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = i_CORE_ADDR;
      mem_wdata_s = i_CORE_WDATA;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  assign core_re_s = (state_r == ST_CALC);

  // State, frozen size and registered handshake/error outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_LOAD;
      n_r        <= {ADDR_WIDTH{1'b0}};
      log2n_r    <= 4'd0;
      start_r    <= 1'b0;
      calc_end_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      n_r        <= n_cur_s;
      log2n_r    <= log2n_cur_s;
      start_r    <= (state_s == ST_START);
      calc_end_r <= (state_s == ST_DONE);
      if ((state_s == ST_LOAD) && (state_r != ST_LOAD)) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  fft_store_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (mem_we_s),
    .i_waddr (mem_waddr_s),
    .i_wdata (mem_wdata_s),
    .i_re    (core_re_s),
    .i_raddr (i_CORE_ADDR),
    .o_rdata (o_CORE_RDATA),
    .i_baddr (i_SAMPLE_INDEX),
    .o_bdata (bdata_s)
  );

  // Bridge samples o_DATA in the same cycle it raises i_READ.
  assign o_DATA     = ((state_r == ST_DONE) && i_READ) ? bdata_s : {DATA_WIDTH{1'b0}};
  assign o_CALC_END = calc_end_r;
  assign o_START    = start_r;
  assign o_LOG2N    = log2n_r;
  assign o_ERR      = err_r;

endmodule

// File: tb/tb_fft_sample_store.sv
// tb_fft_sample_store
//   Directed bench for fft_sample_store: bit-reversed load, read-first core
//   port, natural-order readout, error cases, reset abort, N=2 and N=4096.
module tb_fft_sample_store;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_SAMPLE = 16'h0000;
  logic [11:0] i_SAMPLE_INDEX = 12'h000;
  logic        i_WRITE = 1'b0;
  logic        i_READ = 1'b0;
  logic        i_DATA_LOADED = 1'b0;
  logic [11:0] i_SAMPLES_NUMBER = 12'd8;
  logic [31:0] o_DATA;
  logic        o_CALC_END;
  logic        o_START;
  logic [3:0]  o_LOG2N;
  logic [11:0] i_CORE_ADDR = 12'h000;
  logic        i_CORE_WE = 1'b0;
  logic [31:0] i_CORE_WDATA = 32'h0;
  logic [31:0] o_CORE_RDATA;
  logic        i_CORE_DONE = 1'b0;
  logic        o_ERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_mem [0:7];

  fft_sample_store dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_SAMPLE         (i_SAMPLE),
    .i_SAMPLE_INDEX   (i_SAMPLE_INDEX),
    .i_WRITE          (i_WRITE),
    .i_READ           (i_READ),
    .i_DATA_LOADED    (i_DATA_LOADED),
    .i_SAMPLES_NUMBER (i_SAMPLES_NUMBER),
    .o_DATA           (o_DATA),
    .o_CALC_END       (o_CALC_END),
    .o_START          (o_START),
    .o_LOG2N          (o_LOG2N),
    .i_CORE_ADDR      (i_CORE_ADDR),
    .i_CORE_WE        (i_CORE_WE),
    .i_CORE_WDATA     (i_CORE_WDATA),
    .o_CORE_RDATA     (o_CORE_RDATA),
    .i_CORE_DONE      (i_CORE_DONE),
    .o_ERR            (o_ERR)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bridge write; 'commit' says whether the write is expected to land (N=8 map).
  task automatic bw(input logic [11:0] idx, input logic [15:0] s, input logic last,
                    input logic commit);
    i_WRITE = 1'b1; i_SAMPLE_INDEX = idx; i_SAMPLE = s; i_DATA_LOADED = last;
    tick();
    i_WRITE = 1'b0; i_DATA_LOADED = 1'b0;
    if (commit) exp_mem[rev3(idx[2:0])] = {s, 16'h0000};
  endtask

  task automatic core_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    i_CORE_ADDR = a;
    tick();
    chk(tag, o_CORE_RDATA, exp);
  endtask

  task automatic br(input string tag, input logic [11:0] idx, input logic [31:0] exp);
    i_READ = 1'b1; i_SAMPLE_INDEX = idx;
    #1;
    chk(tag, o_DATA, exp);
    tick();
    i_READ = 1'b0;
  endtask

  task automatic core_done();
    i_CORE_DONE = 1'b1;
    tick();
    i_CORE_DONE = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_data",  o_DATA, 32'h0);
    chk("rst_rdata", o_CORE_RDATA, 32'h0);
    chk("rst_cend",  32'(o_CALC_END), 32'h0);
    chk("rst_start", 32'(o_START), 32'h0);
    chk("rst_err",   32'(o_ERR), 32'h0);
    chk("rst_log2n", 32'(o_LOG2N), 32'h0);
    i_rst = 1'b0;

    // 1: N=8 bit-reversed load, loaded flag with last write
    for (int i = 0; i < 8; i++) begin
      bw(12'(i), 16'h0010 + 16'(i), (i == 7), 1'b1);
    end
    chk("start_pulse", 32'(o_START), 32'h1);
    chk("log2n_8",     32'(o_LOG2N), 32'h3);
    chk("load_err",    32'(o_ERR),   32'h0);
    tick();
    chk("start_once",  32'(o_START), 32'h0);
    core_rd("mem0", 12'd0, 32'h00100000);
    core_rd("mem4", 12'd4, 32'h00110000);
    core_rd("mem1", 12'd1, 32'h00140000);

    // 2: read-first collision on address 3 (holds sample idx 6)
    i_CORE_ADDR = 12'd3; i_CORE_WE = 1'b1; i_CORE_WDATA = 32'hDEADBEEF;
    tick();
    i_CORE_WE = 1'b0;
    chk("rd_first_old", o_CORE_RDATA, 32'h00160000);
    tick();
    chk("rd_after_wr", o_CORE_RDATA, 32'hDEADBEEF);
    exp_mem[3] = 32'hDEADBEEF;

    // 4a: bridge write during CALC is ignored and flagged
    bw(12'd2, 16'hFFFF, 1'b0, 1'b0);
    chk("calc_wr_err", 32'(o_ERR), 32'h1);
    core_rd("calc_wr_drop", 12'd2, 32'h00120000);

    // 3: completion and natural-order readout
    core_done();
    chk("calc_end_on", 32'(o_CALC_END), 32'h1);
    chk("data_idle",   o_DATA, 32'h0);
    i_CORE_ADDR = 12'd0; i_CORE_WE = 1'b1; i_CORE_WDATA = 32'h12345678;
    tick();
    i_CORE_WE = 1'b0;
    chk("core_hold", o_CORE_RDATA, 32'h00120000);
    for (int i = 0; i < 8; i++) begin
      br($sformatf("rdA%0d", i), 12'(i), exp_mem[i]);
    end
    chk("calc_end_off", 32'(o_CALC_END), 32'h0);
    chk("err_clr_load", 32'(o_ERR), 32'h0);

    // 4b: index beyond N dropped; then reload even indices
    bw(12'd9, 16'h0099, 1'b0, 1'b0);
    chk("oob_err", 32'(o_ERR), 32'h1);
    bw(12'd0, 16'h0020, 1'b0, 1'b1);
    bw(12'd2, 16'h0022, 1'b0, 1'b1);
    bw(12'd4, 16'h0024, 1'b0, 1'b1);
    bw(12'd6, 16'h0026, 1'b1, 1'b1);
    tick();
    core_rd("oob_drop", 12'd4, 32'h00110000);

    // 5: reset while in CALC
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("abort_start", 32'(o_START), 32'h0);
    chk("abort_cend",  32'(o_CALC_END), 32'h0);
    chk("abort_err",   32'(o_ERR), 32'h0);
    chk("abort_rdata", o_CORE_RDATA, 32'h0);
    chk("abort_log2n", 32'(o_LOG2N), 32'h0);

    // 4c: N=6 flagged, write dropped, log2N floored
    i_SAMPLES_NUMBER = 12'd6;
    bw(12'd1, 16'hAAAA, 1'b0, 1'b0);
    chk("n6_err",   32'(o_ERR), 32'h1);
    chk("n6_log2n", 32'(o_LOG2N), 32'h2);
    i_SAMPLES_NUMBER = 12'd8;
    bw(12'd1, 16'h0031, 1'b0, 1'b1);
    bw(12'd3, 16'h0033, 1'b0, 1'b1);
    bw(12'd5, 16'h0035, 1'b0, 1'b1);
    bw(12'd7, 16'h0037, 1'b1, 1'b1);
    tick();
    core_done();
    for (int i = 0; i < 8; i++) begin
      br($sformatf("rdC%0d", i), 12'(i), exp_mem[i]);
    end
    chk("err_clr_load2", 32'(o_ERR), 32'h0);

    // 6: N=2 (idx1 -> addr1)
    i_SAMPLES_NUMBER = 12'd2;
    bw(12'd0, 16'h0040, 1'b0, 1'b0);
    bw(12'd1, 16'h0041, 1'b1, 1'b0);
    chk("log2n_2", 32'(o_LOG2N), 32'h1);
    tick();
    core_rd("n2_addr1", 12'd1, 32'h00410000);
    core_rd("n2_addr0", 12'd0, 32'h00400000);
    core_done();
    br("n2_rd0", 12'd0, 32'h00400000);
    br("n2_rd1", 12'd1, 32'h00410000);
    chk("n2_cend_off", 32'(o_CALC_END), 32'h0);
    core_done();
    chk("stray_done_err",  32'(o_ERR), 32'h0);
    chk("stray_done_cend", 32'(o_CALC_END), 32'h0);

    // 6: N=4096 truncates to 0 on a 12-bit port and must be flagged
    i_SAMPLES_NUMBER = 12'h000;
    bw(12'd0, 16'h0050, 1'b0, 1'b0);
    chk("n4096_err", 32'(o_ERR), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
